sample_delay_line: RTL and testbench
====================================

SAMPLE_DELAY_LINE -- requirements
Module: sample_delay_line

Interface
REQ-001 SHALL have parameter WIDTH, default 8: sample width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 16: number of delay stages (2..256).
REQ-003 SHALL have derived parameter TAP_W = ceil(log2(DEPTH)): tap select width.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port nreset, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port en, input, 1: sample enable; all state advances only on en=1, except reset and flush.
REQ-007 SHALL have port prn, input, 1: active-low preset, qualified by en.
REQ-008 SHALL have port flush, input, 1: synchronous clear of pipeline contents and fill count.
REQ-009 SHALL have port d, input, WIDTH: incoming sample.
REQ-010 SHALL have port tap, input, TAP_W: output stage select; delay = tap+1 enabled cycles.
REQ-011 SHALL have port q, output, WIDTH: content of stage[tap].
REQ-012 SHALL have port valid, output, 1: stage[tap] holds a real sample.
REQ-013 SHALL have port full, output, 1: all DEPTH stages hold real samples.
REQ-014 SHALL have port chg, output, 1: registered flag; the last enabled sample differed from its predecessor.

Function
REQ-015 Pipeline: on clk rising edge with en=1 and prn=1, stage[0] <= d and stage[i] <= stage[i-1] for i=1..DEPTH-1.
REQ-016 Hold: with en=0, all stages, the fill count and chg SHALL keep their values.
REQ-017 Preset: with en=1 and prn=0, every stage <= all ones, fill <= DEPTH, and chg <= 0.
REQ-018 Flush: flush=1 SHALL zero all stages, fill and chg regardless of en and prn.
REQ-019 Priority SHALL be nreset > flush > (en & !prn) preset > (en) shift > hold.
REQ-020 Fill counter: width TAP_W+1; +1 per enabled shift; saturates at DEPTH; no wrap.
REQ-021 q SHALL be combinational from stage[tap]; a tap change is reflected in the same cycle.
REQ-022 tap values >= DEPTH (non-power-of-2 DEPTH) SHALL select stage[DEPTH-1].
REQ-023 valid SHALL be combinational: fill > effective tap.
REQ-024 full SHALL be 1 if and only if fill == DEPTH.
REQ-025 chg: on an enabled shift, chg <= (d != stage[0] before the edge).
REQ-026 chg: on the first shift after reset or flush (fill==0), chg <= 0.
REQ-027 Latency: d sampled at enabled edge N SHALL appear on q with tap=k after enabled edge N+k.

Reset
REQ-028 On nreset=0 at a clk edge, all stages, fill and chg SHALL become 0, independent of en, prn and flush.
REQ-029 After reset: q=0, valid=0, full=0, chg=0.
REQ-030 Reset asserted mid-fill SHALL discard all samples; refill restarts from fill=0.
REQ-031 Registers SHALL also power up at 0, matching the reset state.

Structure
REQ-032 Shared package la_pkg SHALL hold the clog2 helper function and the default WIDTH/DEPTH constants.
REQ-033 One sub-module delay_stage (WIDTH-bit register with en, clear, preset) SHALL be instantiated DEPTH times by a generate loop.
REQ-034 Fill counter, tap mux and chg logic SHALL live in the top module; no other sub-modules.

Verification
REQ-035 Reset: drive nreset=0 with en=1 and d=0xA5 -> q=0, valid=0, full=0, chg=0 next cycle.
REQ-036 Latency (WIDTH=8, DEPTH=16, tap=3): feed 0x01,0x02,... with en=1 -> q=0x01 after the 4th edge; valid rises on that same edge.
REQ-037 Gapped enable: en toggles 1/0 each cycle -> fill and outputs advance only on en=1; full after 16 enabled edges.
REQ-038 Preset/flush: prn=0 with en=1 -> q=0xFF and full=1; then flush=1 -> q=0, fill=0; prn=0 with en=0 -> no change.
REQ-039 chg: samples 0x10,0x10,0x11 -> chg = 0,0,1 after the respective edges.
REQ-040 Tap sweep (DEPTH=12): tap=15 returns stage[11]; tap changed mid-stream updates q and valid in the same cycle.

Source files
------------

// File: rtl/la_pkg.sv
`default_nettype none
// ============================================================================
// Module     : la_pkg
// Description: Shared constants and helpers for the sample delay line.
//              Holds the default WIDTH/DEPTH values and a ceil(log2())
//              function used to size the tap select and fill counter.
// Revision   : 1.0 - initial release
// ============================================================================
package la_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // ceil(log2(value)); returns 1 for value <= 2 so a width is never zero.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage : la_pkg
`default_nettype wire

// File: rtl/delay_stage.sv
`default_nettype none
// ============================================================================
// Module     : delay_stage
// Description: One WIDTH-bit storage stage of the delay line.
//              Priority: nreset > clear > (en & preset) > (en) load > hold.
// Ports      : clk    - rising-edge clock
//              nreset - synchronous active-low reset
//              en     - load enable (also qualifies preset)
//              clear  - synchronous clear, independent of en
//              preset - active-high preset to all ones, qualified by en
//              d      - data in (previous stage or incoming sample)
//              q      - stored data
// Revision   : 1.0 - initial release
// ============================================================================
module delay_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en,
  input  logic             clear,
  input  logic             preset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Power-up value matches the reset state.
  logic [WIDTH-1:0] data = '0;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      data <= '0;
    end else if (clear) begin
      data <= '0;
    end else if (en) begin
      data <= preset ? {WIDTH{1'b1}} : d;
    end
  end

  assign q = data;

endmodule : delay_stage
`default_nettype wire

// File: rtl/sample_delay_line.sv
`default_nettype none
// ============================================================================
// Module     : sample_delay_line
// Description: Tapped delay line of DEPTH WIDTH-bit stages with sample
//              enable, preset, flush, fill tracking and change detect.
// Ports      : clk    - rising-edge clock
//              nreset - synchronous active-low reset
//              en     - sample enable
//              prn    - active-low preset (qualified by en)
//              flush  - synchronous clear of stages, fill count and chg
//              d      - incoming sample
//              tap    - output stage select (delay = tap+1 enabled cycles)
//              q      - content of the selected stage (combinational)
//              valid  - selected stage holds a real sample
//              full   - every stage holds a real sample
//              chg    - last enabled sample differed from its predecessor
// Revision   : 1.0 - initial release
// ============================================================================
module sample_delay_line
  import la_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int TAP_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en,
  input  logic             prn,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic [TAP_W-1:0] tap,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             full,
  output logic             chg
);

  localparam logic [TAP_W:0]   DEPTH_F  = (TAP_W + 1)'(DEPTH);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(DEPTH - 1);

  // chain[0] is the incoming sample, chain[i+1] is stage[i].
  logic [DEPTH:0][WIDTH-1:0]   chain;
  logic [DEPTH-1:0][WIDTH-1:0] stages;
  logic                        preset;
  logic [TAP_W-1:0]            eff_tap;
  logic [TAP_W:0]              fill     = '0;
  logic                        chg_flag = 1'b0;

  assign chain[0] = d;
  assign stages   = chain[DEPTH:1];
  assign preset   = ~prn;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    delay_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk    (clk),
      .nreset (nreset),
      .en     (en),
      .clear  (flush),
      .preset (preset),
      .d      (chain[i]),
      .q      (chain[i+1])
    );
  end

  // Out-of-range taps (only possible with non-power-of-2 DEPTH) clamp
  // to the last stage.
  always_comb begin
    eff_tap = tap;
    if ({1'b0, tap} >= DEPTH_F) begin
      eff_tap = LAST_TAP;
    end
  end

  assign q     = stages[eff_tap];
  assign valid = (fill > {1'b0, eff_tap});
  assign full  = (fill == DEPTH_F);
  assign chg   = chg_flag;

  // Fill count and change flag follow the same priority as the stages.
  // With fill==0 stage[0] holds no real sample, so no change is reported.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      fill     <= '0;
      chg_flag <= 1'b0;
    end else if (flush) begin
      fill     <= '0;
      chg_flag <= 1'b0;
    end else if (en && !prn) begin
      fill     <= DEPTH_F;
      chg_flag <= 1'b0;
    end else if (en) begin
      if (fill != DEPTH_F) begin
        fill <= fill + 1'b1;
      end
      chg_flag <= (fill != '0) && (d != stages[0]);
    end
  end

endmodule : sample_delay_line
`default_nettype wire

// File: tb/tb_sample_delay_line.sv
`default_nettype none
// ============================================================================
// Module     : tb_sample_delay_line
// Description: Directed self-checking bench for sample_delay_line. Drives a
//              DEPTH=16 instance and a DEPTH=12 instance from shared control
//              inputs, each with its own tap select.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_sample_delay_line;

  logic       clk = 1'b0;
  logic       nreset;
  logic       en;
  logic       prn;
  logic       flush;
  logic [7:0] d;
  logic [3:0] tap_a;
  logic [3:0] tap_b;
  logic [7:0] q_a, q_b;
  logic       valid_a, valid_b, full_a, full_b, chg_a, chg_b;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sample_delay_line #(.WIDTH(8), .DEPTH(16)) u_dut_a (
    .clk (clk), .nreset (nreset), .en (en), .prn (prn), .flush (flush),
    .d (d), .tap (tap_a), .q (q_a), .valid (valid_a), .full (full_a),
    .chg (chg_a)
  );

  sample_delay_line #(.WIDTH(8), .DEPTH(12)) u_dut_b (
    .clk (clk), .nreset (nreset), .en (en), .prn (prn), .flush (flush),
    .d (d), .tap (tap_b), .q (q_b), .valid (valid_b), .full (full_b),
    .chg (chg_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests_run = tests_run + 1;
    assert (obs === exp) else begin
      tests_failed = tests_failed + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    nreset = 1'b0;
    en     = 1'b1;
    prn    = 1'b1;
    flush  = 1'b0;
    d      = 8'hA5;
    tap_a  = 4'd3;
    tap_b  = 4'd15;

    // Reset with en=1 and a live sample on d.
    tick();
    check("rst_q",     q_a,     8'h00);
    check("rst_valid", valid_a, 1'b0);
    check("rst_full",  full_a,  1'b0);
    check("rst_chg",   chg_a,   1'b0);

    // Latency at tap=3.
    nreset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d = 8'(i);
      tick();
      if (i == 3) begin
        check("lat_q_e3",     q_a,     8'h00);
        check("lat_valid_e3", valid_a, 1'b0);
      end
    end
    check("lat_q_e4",     q_a,     8'h01);
    check("lat_valid_e4", valid_a, 1'b1);
    check("lat_chg",      chg_a,   1'b1);

    // Reset mid-fill discards everything.
    nreset = 1'b0;
    tick();
    check("midrst_q",     q_a,     8'h00);
    check("midrst_valid", valid_a, 1'b0);
    nreset = 1'b1;

    // Gapped enable: only the en=1 edges advance the line.
    for (int n = 1; n <= 16; n++) begin
      en = 1'b1;
      d  = 8'(n);
      tick();
      if (n == 11) check("gap_full_b_11", full_b, 1'b0);
      if (n == 12) check("gap_full_b_12", full_b, 1'b1);
      if (n == 15) check("gap_full_a_15", full_a, 1'b0);
      if (n == 16) begin
        check("gap_full_a_16", full_a, 1'b1);
        check("gap_q_a_16",    q_a,    8'd13);
      end
      en = 1'b0;
      d  = 8'hEE;
      tick();
      if (n == 2)  check("gap_valid_hold", valid_a, 1'b0);
      if (n == 15) check("gap_full_hold",  full_a,  1'b0);
      if (n == 16) check("gap_q_hold",     q_a,     8'd13);
    end

    // Clamped tap on DEPTH=12 and same-cycle tap changes.
    check("tap15_q_b",     q_b,     8'd5);
    check("tap15_valid_b", valid_b, 1'b1);
    tap_b = 4'd0;
    #1;
    check("tap0_q_b", q_b, 8'd16);
    tap_b = 4'd11;
    #1;
    check("tap11_q_b", q_b, 8'd5);

    // Preset, then saturation of the fill count.
    en  = 1'b1;
    prn = 1'b0;
    tick();
    check("pre_q_a",    q_a,    8'hFF);
    check("pre_full_a", full_a, 1'b1);
    check("pre_full_b", full_b, 1'b1);
    check("pre_chg",    chg_a,  1'b0);
    prn = 1'b1;
    d   = 8'h33;
    tick();
    check("sat_full",  full_a, 1'b1);
    check("sat_q_a",   q_a,    8'hFF);
    check("sat_chg",   chg_a,  1'b1);
    tap_a = 4'd0;
    #1;
    check("sat_q_tap0", q_a, 8'h33);
    tap_a = 4'd3;

    // Flush beats preset and needs no enable.
    en    = 1'b1;
    prn   = 1'b0;
    flush = 1'b1;
    tick();
    check("flush_q",     q_a,     8'h00);
    check("flush_valid", valid_a, 1'b0);
    check("flush_full",  full_a,  1'b0);
    check("flush_chg",   chg_a,   1'b0);
    en = 1'b0;
    d  = 8'h5A;
    tick();
    check("flush_noen_q", q_a, 8'h00);
    flush = 1'b0;

    // Preset without enable has no effect.
    prn = 1'b0;
    en  = 1'b0;
    tick();
    check("prn_noen_q",    q_a,    8'h00);
    check("prn_noen_full", full_a, 1'b0);
    prn = 1'b1;

    // Change detect: 0x10, 0x10, 0x11, then a held cycle.
    en = 1'b1;
    d  = 8'h10;
    tick();
    check("chg_1", chg_a, 1'b0);
    tick();
    check("chg_2", chg_a, 1'b0);
    d = 8'h11;
    tick();
    check("chg_3", chg_a, 1'b1);
    en = 1'b0;
    d  = 8'h22;
    tick();
    check("chg_hold", chg_a, 1'b1);

    // Mid-stream tap sweep on DEPTH=12 with three samples loaded.
    tap_b = 4'd2;
    #1;
    check("sweep_q2",     q_b,     8'h10);
    check("sweep_valid2", valid_b, 1'b1);
    tap_b = 4'd3;
    #1;
    check("sweep_q3",     q_b,     8'h00);
    check("sweep_valid3", valid_b, 1'b0);
    tap_b = 4'd0;
    #1;
    check("sweep_q0", q_b, 8'h11);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_sample_delay_line
`default_nettype wire
